// File: rtl/stack_ctrl.sv
// Push/pop sequencer for the stack_pointer register and its data memory port.
// Bounds are checked on acceptance; every output is registered.
module stack_ctrl #(
    parameter logic [31:0] SP_BASE  = 32'h0000_1000,
    parameter logic [31:0] SP_LIMIT = 32'h0000_0F00,
    parameter logic [31:0] STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_data,
    input  logic [31:0] sp_q,
    output logic        sp_en,
    output logic        sp_dec,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        overflow,
    output logic        underflow,
    input  logic        clr_err
);

    typedef enum logic [2:0] {
        IDLE, PUSH_DEC, PUSH_WR, POP_RD, POP_INC, DONE, ERR
    } state_t;

    state_t      state;
    logic        op_q;
    logic [31:0] data_q;
    logic        accept;
    logic        push_bad;
    logic        pop_bad;

    assign accept   = req_valid && req_ready;
    assign push_bad = sp_q < (SP_LIMIT + STEP);
    assign pop_bad  = sp_q >= SP_BASE;

    // Request payload only matters after acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= req_op;
            data_q <= req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            sp_en      <= 1'b0;
            sp_dec     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            sp_en      <= 1'b0;
            sp_dec     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            // Clear first so a flag set later in this block takes priority.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (!req_op && push_bad) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            overflow   <= 1'b1;
                        end else if (req_op && pop_bad) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            underflow  <= 1'b1;
                        end else if (!req_op) begin
                            state  <= PUSH_DEC;
                            sp_en  <= 1'b1;
                            sp_dec <= 1'b1;
                        end else begin
                            state    <= POP_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= sp_q;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                PUSH_DEC: begin
                    // sp_q decrements on this same edge; address the new slot.
                    state     <= PUSH_WR;
                    mem_we    <= 1'b1;
                    mem_addr  <= sp_q - STEP;
                    mem_wdata <= data_q;
                end
                PUSH_WR: begin
                    if (mem_ready) begin
                        state      <= DONE;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                    end
                end
                POP_RD: begin
                    if (mem_ready) begin
                        state     <= POP_INC;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        resp_data <= mem_rdata;
                        sp_en     <= 1'b1;
                    end
                end
                POP_INC: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    if (op_q) underflow <= 1'b1;
                    else      overflow  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack_pointer and memory.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic [31:0] sp;
    logic        sp_en;
    logic        sp_dec;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        overflow;
    logic        underflow;
    logic        clr_err;

    logic        sp_ld;
    logic [31:0] sp_ld_val;
    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
        .sp_q(sp), .sp_en(sp_en), .sp_dec(sp_dec),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    // Behavioural stack_pointer: loadable by the bench, never touched by rst.
    always @(posedge clk) begin
        if (sp_ld)      sp <= sp_ld_val;
        else if (sp_en) sp <= sp_dec ? sp - 32'd4 : sp + 32'd4;
    end

    always @(posedge clk) begin
        if (mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    typedef struct {
        logic        op;
        logic [31:0] sp0;
        logic [31:0] data;
        int          stall;
        logic        clr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] sp1;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; the DUT is in or returning to IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        int          lat;
        int          nen;
        int          nbad;
        int          stalls;
        logic        seen;
        logic [31:0] a;
        logic [31:0] wd;
        int          exp_lat;
        lat = 0; nen = 0; nbad = 0; stalls = 0; seen = 1'b0; a = '0; wd = '0;
        exp_lat = v.err ? 1 : 3 + v.stall;
        sp_ld = 1'b1; sp_ld_val = v.sp0; clr_err = v.clr;
        @(posedge clk); #1;
        sp_ld = 1'b0;
        check($sformatf("v%0d ready", idx), req_ready, 1'b1);
        req_valid = 1'b1; req_op = v.op; req_data = v.data; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = 32'h0BAD_0BAD; clr_err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (sp_en) begin
                nen++;
                if (sp_dec !== !v.op) nbad++;
            end
            if (int'(sp_en) + int'(mem_we) + int'(mem_re) > 1) nbad++;
            if (mem_we || mem_re) begin
                if (!seen) begin
                    seen = 1'b1; a = mem_addr; wd = mem_wdata;
                end else if (mem_addr !== a || mem_wdata !== wd) begin
                    nbad++;
                end
                mem_ready = (stalls >= v.stall);
                stalls++;
            end else begin
                mem_ready = 1'b0;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        check($sformatf("v%0d latency", idx), lat, exp_lat);
        check($sformatf("v%0d resp_err", idx), resp_err, v.err);
        check($sformatf("v%0d mem_addr", idx), a, v.addr);
        if (!v.err && !v.op) check($sformatf("v%0d mem_wdata", idx), wd, v.data);
        if (!v.err && v.op)  check($sformatf("v%0d resp_data", idx), resp_data, v.rdata);
        check($sformatf("v%0d sp_en count", idx), nen, v.err ? 0 : 1);
        check($sformatf("v%0d protocol", idx), nbad, 0);
        check($sformatf("v%0d sp_q", idx), sp, v.sp1);
        check($sformatf("v%0d flags", idx), {overflow, underflow}, {v.ovf, v.unf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //             op    sp0           data          st clr  err   addr          rdata         sp1           ovf   unf
        tbl[0]  = '{1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0000_0FFC, 32'h0,        32'h0000_0FFC, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0FFC, 32'h0,         0, 1'b0, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_1000, 32'h0,         0, 1'b0, 1'b1, 32'h0,         32'h0,        32'h0000_1000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 32'h0000_0F00, 32'h1,         0, 1'b0, 1'b1, 32'h0,         32'h0,        32'h0000_0F00, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0000_0F04, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h0000_0F00, 32'h0,        32'h0000_0F00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0F00, 32'h0,         2, 1'b0, 1'b0, 32'h0000_0F00, 32'h1234_5678, 32'h0000_0F04, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0F03, 32'h2,         0, 1'b0, 1'b1, 32'h0,         32'h0,        32'h0000_0F03, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 0, 1'b1, 1'b0, 32'h0000_0FF8, 32'h0,        32'h0000_0FF8, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0FF8, 32'h0,         1, 1'b0, 1'b0, 32'h0000_0FF8, 32'hA5A5_A5A5, 32'h0000_0FFC, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 32'h0,         3, 1'b0, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFF_FFF0, 32'h0,         0, 1'b0, 1'b1, 32'h0,         32'h0,        32'hFFFF_FFF0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 32'h0000_0000, 32'h3,         0, 1'b1, 1'b1, 32'h0,         32'h0,        32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_data = '0;
        mem_ready = 1'b0; clr_err = 1'b0; sp_ld = 1'b1; sp_ld_val = 32'h0000_1000;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", req_ready, 1'b0);
        check("reset ctl", {sp_en, sp_dec, mem_we, mem_re, resp_valid, resp_err, overflow, underflow}, 8'h00);
        check("reset resp_data", resp_data, 32'h0);
        check("reset mem bus", {mem_addr, mem_wdata}, 64'h0);
        rst = 1'b1; sp_ld = 1'b0;
        @(posedge clk); #1;
        check("idle ready", req_ready, 1'b1);
        check("idle strobes", {sp_en, mem_we, mem_re}, 3'b000);
        @(posedge clk); #1;
        check("idle strobes 2", {sp_en, mem_we, mem_re, req_ready}, 4'b0001);

        for (int i = 0; i < 12; i++) run_txn(tbl[i], i);

        // Memory stall with a competing request held during the push
        sp_ld = 1'b1; sp_ld_val = 32'h0000_1000;
        @(posedge clk); #1;
        sp_ld = 1'b0;
        req_valid = 1'b1; req_op = 1'b0; req_data = 32'hCAFE_F00D; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_op = 1'b1;
        check("stall c1", {sp_en, sp_dec, req_ready}, 3'b110);
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall c%0d we/ready/addr", c), {mem_we, req_ready, mem_addr}, {2'b10, 32'h0000_0FFC});
            check($sformatf("stall c%0d wdata", c), mem_wdata, 32'hCAFE_F00D);
            mem_ready = (c == 5);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("stall c6 resp", {resp_valid, resp_err, req_ready, mem_we}, 4'b1000);
        req_valid = 1'b0;
        for (int c = 7; c <= 8; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall c%0d idle", c), {sp_en, mem_we, mem_re, resp_valid, req_ready}, 5'b00001);
        end
        check("stall sp", sp, 32'h0000_0FFC);
        check("stall memory", mem[8'hFF], 32'hCAFE_F00D);

        // clr_err held across an error: the set must win
        sp_ld = 1'b1; sp_ld_val = 32'h0000_0F00; clr_err = 1'b1;
        @(posedge clk); #1;
        sp_ld = 1'b0;
        check("clr flags", {overflow, underflow}, 2'b00);
        req_valid = 1'b1; req_op = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("clr+err c1", {resp_valid, resp_err, overflow}, 3'b111);
        @(posedge clk); #1;
        check("clr+err c2 set wins", {overflow, underflow}, 2'b10);
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("clr after err", {overflow, underflow}, 2'b00);

        // Reset in PUSH_WR
        sp_ld = 1'b1; sp_ld_val = 32'h0000_1000;
        @(posedge clk); #1;
        sp_ld = 1'b0;
        req_valid = 1'b1; req_op = 1'b0; req_data = 32'h1122_3344; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst in PUSH_WR", {mem_we, mem_addr}, {1'b1, 32'h0000_0FFC});
        #1 rst = 1'b0;
        #1;
        check("midrst async drop", {mem_we, mem_re, sp_en, req_ready, mem_addr, mem_wdata}, 68'h0);
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("midrst idle %0d", c), {resp_valid, mem_we, mem_re, sp_en, req_ready}, 5'b00001);
        end
        check("midrst sp kept", sp, 32'h0000_0FFC);
        run_txn('{1'b0, 32'h0000_0FFC, 32'h5566_7788, 0, 1'b1, 1'b0, 32'h0000_0FF8, 32'h0, 32'h0000_0FF8, 1'b0, 1'b0}, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
